// File: rtl/bkram_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bkram_sync_ctrl
// Brief    : Multi-region backup-RAM save/load sequencer. Walks every present
//            and enabled save region sector by sector and issues read (load)
//            or write (save) requests to the HPS sector interface. It also
//            tracks which regions are dirty, runs a watchdog on each ack, and
//            starts an automatic load after a ROM download.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: BKRAM_AUTOSAVE_EN
//   When defined, an idle counter (AUTOSAVE_IDLE cycles, reloaded on every
//   core write) starts a save of the dirty regions once the core goes quiet.
// ----------------------------------------------------------------------------
// Ports:
//   clk_sys      in   system clock
//   reset        in   synchronous, active-low
//   ena_i        in   per-region: image mounted and writable
//   mask_i       in   per-region byte-size mask (size-1), 0 = absent
//   base_lba_i   in   per-region first image LBA
//   wr_strobe_i  in   per-region core write (marks region dirty)
//   load_req     in   level, rising edge starts a load
//   save_req     in   level, rising edge starts a save
//   dl_done      in   pulse at end of ROM download, requests a load
//   sd_ack       in   HPS acknowledge
//   sd_lba       out  sector address (region base + local sector)
//   sd_rd/sd_wr  out  sector read / write request
//   region_sel   out  region whose RAM is muxed onto sd_buff
//   local_sector out  sector index inside the current region
//   busy         out  operation in progress
//   loading      out  high throughout a load
//   dirty        out  per-region modified-since-last-save flags
//   error        out  sticky: last operation aborted on ack timeout
//   done         out  one-cycle pulse when an operation ends
// ============================================================================
module bkram_sync_ctrl #(
    parameter int NUM_REGIONS = 2,
    parameter int LBA_W       = 32,
    parameter int MASK_W      = 24,
    parameter int SECTOR_BITS = 9,
    parameter int ACK_TIMEOUT = 2**24
`ifdef BKRAM_AUTOSAVE_EN
    ,
    parameter int AUTOSAVE_IDLE = 2**26
`endif
) (
    input  logic                                             clk_sys,
    input  logic                                             reset,
    input  logic [NUM_REGIONS-1:0]                           ena_i,
    input  logic [NUM_REGIONS*MASK_W-1:0]                    mask_i,
    input  logic [NUM_REGIONS*LBA_W-1:0]                     base_lba_i,
    input  logic [NUM_REGIONS-1:0]                           wr_strobe_i,
    input  logic                                             load_req,
    input  logic                                             save_req,
    input  logic                                             dl_done,
    input  logic                                             sd_ack,
    output logic [LBA_W-1:0]                                 sd_lba,
    output logic                                             sd_rd,
    output logic                                             sd_wr,
    output logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] region_sel,
    output logic [MASK_W-SECTOR_BITS-1:0]                    local_sector,
    output logic                                             busy,
    output logic                                             loading,
    output logic [NUM_REGIONS-1:0]                           dirty,
    output logic                                             error,
    output logic                                             done
);

    localparam int c_SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    // Scan index must be able to hold NUM_REGIONS ("past the last region").
    localparam int c_IDX_W = $clog2(NUM_REGIONS + 1);
    localparam int c_LS_W  = MASK_W - SECTOR_BITS;
    localparam int c_WD_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SELECT    = 3'd1;
    localparam logic [2:0] c_ST_REQ       = 3'd2;
    localparam logic [2:0] c_ST_WAIT_RISE = 3'd3;
    localparam logic [2:0] c_ST_WAIT_FALL = 3'd4;
    localparam logic [2:0] c_ST_FINISH    = 3'd5;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;

    logic                   r_load_q;
    logic                   r_save_q;
    logic                   r_ack_q;
    logic                   r_pending_load;
    logic                   r_op_load;
    logic [c_IDX_W-1:0]     r_index;
    logic [c_SEL_W-1:0]     r_region_sel;
    logic [c_LS_W-1:0]      r_local_sector;
    logic [LBA_W-1:0]       r_sd_lba;
    logic                   r_sd_rd;
    logic                   r_sd_wr;
    logic                   r_busy;
    logic                   r_loading;
    logic [NUM_REGIONS-1:0] r_dirty;
    logic                   r_error;
    logic                   r_done;
    logic [c_WD_W-1:0]      r_wdog;

    logic                   w_load_rise;
    logic                   w_save_rise;
    logic                   w_ack_rise;
    logic                   w_ack_fall;
    logic                   w_start_load;
    logic                   w_auto_req;
    logic                   w_only_dirty;
    logic                   w_start;
    logic [NUM_REGIONS-1:0] w_present;
    logic                   w_sel_found;
    logic [c_SEL_W-1:0]     w_sel_idx;
    logic [LBA_W-1:0]       w_cur_base;
    logic [c_LS_W-1:0]      w_end_sector;
    logic                   w_last;
    logic                   w_timeout;
    logic [NUM_REGIONS-1:0] w_dirty_next;

    // ------------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------------
    assign w_load_rise = load_req & ~r_load_q;
    assign w_save_rise = save_req & ~r_save_q;
    assign w_ack_rise  = sd_ack & ~r_ack_q;
    assign w_ack_fall  = ~sd_ack & r_ack_q;

    // A pending post-download load is treated exactly like a load edge.
    assign w_start_load = w_load_rise | r_pending_load;
    assign w_start      = (r_state == c_ST_IDLE) &&
                          (w_start_load || w_save_rise || w_auto_req);

    // ------------------------------------------------------------------------
    // Optional idle-triggered autosave
    // ------------------------------------------------------------------------
`ifdef BKRAM_AUTOSAVE_EN
    localparam int c_AS_W = (AUTOSAVE_IDLE > 1) ? $clog2(AUTOSAVE_IDLE + 1) : 1;

    logic [c_AS_W-1:0] r_idle_cnt;
    logic              r_only_dirty;
    logic              w_start_auto;

    // Autosave has the lowest priority of all start sources.
    assign w_start_auto = w_start && !w_start_load && !w_save_rise;
    assign w_auto_req   = (r_idle_cnt == '0) && |(r_dirty & ena_i & w_present);
    assign w_only_dirty = r_only_dirty;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_idle_cnt   <= c_AS_W'(AUTOSAVE_IDLE);
            r_only_dirty <= 1'b0;
        end else begin
            // Reloading on start keeps one quiet period from firing twice.
            if ((|wr_strobe_i) || w_start) begin
                r_idle_cnt <= c_AS_W'(AUTOSAVE_IDLE);
            end else if (r_idle_cnt != '0) begin
                r_idle_cnt <= r_idle_cnt - c_AS_W'(1);
            end
            if (w_start) begin
                r_only_dirty <= w_start_auto;
            end
        end
    end
`else
    assign w_auto_req   = 1'b0;
    assign w_only_dirty = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Region lookup
    // ------------------------------------------------------------------------
    always_comb begin
        w_present = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_present[i] = |mask_i[i*MASK_W +: MASK_W];
        end
    end

    // Lowest eligible region at or above the scan index; iterating downward
    // lets the last hit be the lowest one.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((i >= int'(r_index)) && ena_i[i] && w_present[i] &&
                (!w_only_dirty || r_dirty[i])) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_cur_base   = '0;
        w_end_sector = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (c_SEL_W'(i) == r_region_sel) begin
                w_cur_base   = base_lba_i[i*LBA_W +: LBA_W];
                w_end_sector = mask_i[i*MASK_W + SECTOR_BITS +: c_LS_W];
            end
        end
    end

    // End test runs before any increment, so local_sector never wraps.
    assign w_last    = (r_local_sector >= w_end_sector);
    assign w_timeout = (r_wdog <= c_WD_W'(1));

    // Save clears the region's flag on its first sector; a core write in the
    // same cycle re-marks it so no modification is ever lost.
    always_comb begin
        w_dirty_next = r_dirty;
        if ((r_state == c_ST_REQ) && !r_op_load && (r_local_sector == '0)) begin
            w_dirty_next[r_region_sel] = 1'b0;
        end
        w_dirty_next = w_dirty_next | wr_strobe_i;
    end

    // ------------------------------------------------------------------------
    // Sequencer state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_next_state = c_ST_SELECT;
                end
            end
            c_ST_SELECT: begin
                w_next_state = w_sel_found ? c_ST_REQ : c_ST_FINISH;
            end
            c_ST_REQ: begin
                w_next_state = c_ST_WAIT_RISE;
            end
            c_ST_WAIT_RISE: begin
                if (w_ack_rise) begin
                    w_next_state = c_ST_WAIT_FALL;
                end else if (w_timeout) begin
                    w_next_state = c_ST_FINISH;
                end
            end
            c_ST_WAIT_FALL: begin
                if (w_ack_fall) begin
                    w_next_state = w_last ? c_ST_SELECT : c_ST_REQ;
                end
            end
            c_ST_FINISH: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_load_q       <= 1'b0;
            r_save_q       <= 1'b0;
            r_ack_q        <= 1'b0;
            r_pending_load <= 1'b0;
            r_op_load      <= 1'b0;
            r_index        <= '0;
            r_region_sel   <= '0;
            r_local_sector <= '0;
            r_sd_lba       <= '0;
            r_sd_rd        <= 1'b0;
            r_sd_wr        <= 1'b0;
            r_busy         <= 1'b0;
            r_loading      <= 1'b0;
            r_dirty        <= '0;
            r_error        <= 1'b0;
            r_done         <= 1'b0;
            r_wdog         <= '0;
        end else begin
            r_load_q <= load_req;
            r_save_q <= save_req;
            r_ack_q  <= sd_ack;
            r_done   <= 1'b0;
            r_dirty  <= w_dirty_next;

            // Every IDLE cycle consumes the pending flag, since a pending
            // load always wins arbitration there.
            if (dl_done) begin
                r_pending_load <= 1'b1;
            end else if (r_state == c_ST_IDLE) begin
                r_pending_load <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_busy    <= 1'b1;
                        r_loading <= w_start_load;
                        r_op_load <= w_start_load;
                        r_error   <= 1'b0;
                        r_index   <= '0;
                    end
                end
                c_ST_SELECT: begin
                    if (w_sel_found) begin
                        r_region_sel   <= w_sel_idx;
                        r_local_sector <= '0;
                    end
                end
                c_ST_REQ: begin
                    r_sd_lba <= w_cur_base + LBA_W'(r_local_sector);
                    r_sd_rd  <= r_op_load;
                    r_sd_wr  <= ~r_op_load;
                    r_wdog   <= c_WD_W'(ACK_TIMEOUT);
                end
                c_ST_WAIT_RISE: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                    end else if (w_timeout) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog - c_WD_W'(1);
                    end
                end
                c_ST_WAIT_FALL: begin
                    if (w_ack_fall) begin
                        if (w_last) begin
                            r_index <= c_IDX_W'(r_region_sel) + c_IDX_W'(1);
                        end else begin
                            r_local_sector <= r_local_sector + c_LS_W'(1);
                        end
                    end
                end
                c_ST_FINISH: begin
                    r_sd_rd   <= 1'b0;
                    r_sd_wr   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_loading <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_sd_rd <= 1'b0;
                    r_sd_wr <= 1'b0;
                end
            endcase
        end
    end

    assign sd_lba       = r_sd_lba;
    assign sd_rd        = r_sd_rd;
    assign sd_wr        = r_sd_wr;
    assign region_sel   = r_region_sel;
    assign local_sector = r_local_sector;
    assign busy         = r_busy;
    assign loading      = r_loading;
    assign dirty        = r_dirty;
    assign error        = r_error;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bkram_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bkram_sync_ctrl
// Brief    : Self-checking bench for bkram_sync_ctrl. An HPS responder acks
//            each sector request and records it; a region/sector model
//            predicts the request list and the dirty flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bkram_sync_ctrl;

    localparam int c_NR   = 2;
    localparam int c_LBAW = 32;
    localparam int c_MW   = 24;
    localparam int c_SB   = 9;
    localparam int c_TO   = 100;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic [c_NR-1:0]      ena_i;
    logic [c_MW-1:0]      tb_mask [c_NR];
    logic [c_LBAW-1:0]    tb_base [c_NR];
    logic [c_NR*c_MW-1:0] mask_i;
    logic [c_NR*c_LBAW-1:0] base_lba_i;
    logic [c_NR-1:0]      wr_strobe_i;
    logic                 load_req;
    logic                 save_req;
    logic                 dl_done;
    logic                 sd_ack;
    logic [c_LBAW-1:0]    sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 region_sel;
    logic [c_MW-c_SB-1:0] local_sector;
    logic                 busy;
    logic                 loading;
    logic [c_NR-1:0]      dirty;
    logic                 error;
    logic                 done;

    assign mask_i     = {tb_mask[1], tb_mask[0]};
    assign base_lba_i = {tb_base[1], tb_base[0]};

    bkram_sync_ctrl #(
        .NUM_REGIONS (c_NR),
        .LBA_W       (c_LBAW),
        .MASK_W      (c_MW),
        .SECTOR_BITS (c_SB),
        .ACK_TIMEOUT (c_TO)
    ) u_dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ena_i        (ena_i),
        .mask_i       (mask_i),
        .base_lba_i   (base_lba_i),
        .wr_strobe_i  (wr_strobe_i),
        .load_req     (load_req),
        .save_req     (save_req),
        .dl_done      (dl_done),
        .sd_ack       (sd_ack),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .region_sel   (region_sel),
        .local_sector (local_sector),
        .busy         (busy),
        .loading      (loading),
        .dirty        (dirty),
        .error        (error),
        .done         (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_err    = 0;

    // Responder / monitor state
    int  hps_st = 0;
    int  hps_dly = 0;
    int  dly_fixed = 4;
    bit  ack_en = 1'b1;
    int  cyc = 0;
    int  done_cnt = 0;
    int  rd_hi = 0;
    int  loading_bad = 0;
    int  dirty_clr_bad = 0;
    int  last_done_cyc = -1;
    int  lat = -1;
    bit  exp_load = 1'b1;
    bit  chk_loading = 1'b1;
    logic [c_NR-1:0] mdirty = '0;
    logic [63:0] obs_q [$];
    logic [63:0] exp_q [$];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 ns after the edge, then act as the HPS.
    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (sd_rd) rd_hi++;
        if (chk_loading && busy && (loading != exp_load)) loading_bad++;
        if (ack_en) begin
            case (hps_st)
                0: begin
                    if (sd_rd || sd_wr) begin
                        obs_q.push_back({23'd0, sd_wr, 8'(region_sel), sd_lba});
                        if (sd_wr && (local_sector == '0) && dirty[region_sel]) dirty_clr_bad++;
                        if (sd_rd && (last_done_cyc >= 0) && (lat < 0)) lat = cyc - last_done_cyc;
                        hps_dly = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 3));
                        hps_st  = 1;
                    end
                end
                1: begin
                    if (hps_dly <= 1) begin
                        sd_ack = 1'b1;
                        hps_st = 2;
                    end else begin
                        hps_dly--;
                    end
                end
                default: begin
                    sd_ack = 1'b0;
                    hps_st = 0;
                end
            endcase
        end
    endtask

    // Expected request list: every enabled, present region in ascending
    // order, sectors 0 .. mask>>SECTOR_BITS, LBA = base + sector (mod 2^32).
    function automatic void model(input bit wr, input logic [c_NR-1:0] en);
        for (int r = 0; r < c_NR; r++) begin
            if (en[r] && (tb_mask[r] != '0)) begin
                int ns;
                ns = int'(tb_mask[r] >> c_SB);
                for (int s = 0; s <= ns; s++) begin
                    logic [31:0] l;
                    l = tb_base[r] + 32'(s);
                    exp_q.push_back({23'd0, wr, 8'(r), l});
                end
                if (wr) mdirty[r] = 1'b0;
            end
        end
    endfunction

    task automatic strobe(input logic [c_NR-1:0] m);
        wr_strobe_i = m;
        step();
        wr_strobe_i = '0;
        mdirty = mdirty | m;
    endtask

    task automatic run_op(input bit do_load, input bit do_save, input int n_done,
                          input int mid_act, input int mid_at);
        obs_q.delete();
        done_cnt = 0; rd_hi = 0; loading_bad = 0; dirty_clr_bad = 0;
        last_done_cyc = -1; lat = -1;
        load_req = do_load;
        save_req = do_save;
        for (int i = 1; i <= 4000; i++) begin
            step();
            if (i == 1) begin
                load_req = 1'b0;
                save_req = 1'b0;
            end
            if (i == mid_at) begin
                if (mid_act == 1) save_req = 1'b1;
                if (mid_act == 2) dl_done = 1'b1;
            end
            if (i == mid_at + 1) begin
                save_req = 1'b0;
                dl_done  = 1'b0;
            end
            if ((done_cnt >= n_done) && (i > mid_at + 1)) break;
        end
        repeat (6) step();
        check_value("done_pulses", 64'(done_cnt), 64'(n_done));
    endtask

    task automatic cmp_queues(input string tag);
        check_value({tag, "_nreq"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++) begin
            check_value($sformatf("%s_req%0d", tag, i), obs_q[i], exp_q[i]);
        end
    endtask

    initial begin
        reset = 1'b0; ena_i = '0; wr_strobe_i = '0;
        load_req = 1'b0; save_req = 1'b0; dl_done = 1'b0; sd_ack = 1'b0;
        tb_mask[0] = '0; tb_mask[1] = '0; tb_base[0] = '0; tb_base[1] = '0;

        // Reset state
        repeat (3) step();
        check_value("rst_sd_rd",   64'(sd_rd), 0);
        check_value("rst_sd_wr",   64'(sd_wr), 0);
        check_value("rst_sd_lba",  64'(sd_lba), 0);
        check_value("rst_busy",    64'(busy), 0);
        check_value("rst_loading", 64'(loading), 0);
        check_value("rst_dirty",   64'(dirty), 0);
        check_value("rst_error",   64'(error), 0);
        check_value("rst_done",    64'(done), 0);
        check_value("rst_rsel",    64'(region_sel), 0);
        check_value("rst_lsec",    64'(local_sector), 0);
        reset = 1'b1;
        step();

        // Two-region load
        tb_mask[0] = 24'h1FFF; tb_mask[1] = 24'h7FF;
        tb_base[0] = 32'd0;    tb_base[1] = 32'd16;
        ena_i = 2'b11; dly_fixed = 4;
        exp_q.delete(); model(1'b0, 2'b11);
        exp_load = 1'b1;
        run_op(1'b1, 1'b0, 1, 0, 0);
        cmp_queues("load2");
        check_value("load2_loading", 64'(loading_bad), 0);
        check_value("load2_error", 64'(error), 0);
        check_value("load2_busy_end", 64'(busy), 0);
        check_value("load2_loading_end", 64'(loading), 0);

        // Save with region 0 disabled
        strobe(2'b11);
        check_value("dirty_set", 64'(dirty), 64'(mdirty));
        ena_i = 2'b10;
        exp_q.delete(); model(1'b1, 2'b10);
        exp_load = 1'b0;
        run_op(1'b0, 1'b1, 1, 0, 0);
        cmp_queues("save1");
        check_value("save1_dirty_clr", 64'(dirty_clr_bad), 0);
        check_value("save1_dirty", 64'(dirty), 64'(mdirty));
        check_value("save1_rsel", 64'(region_sel), 1);

        // Load/save collision plus a save edge while busy
        ena_i = 2'b11;
        exp_q.delete(); model(1'b0, 2'b11);
        exp_load = 1'b1;
        run_op(1'b1, 1'b1, 1, 1, 10);
        cmp_queues("coll");

        // dl_done during a save: save completes, then a load follows
        strobe(2'b01);
        exp_q.delete(); model(1'b1, 2'b11); model(1'b0, 2'b11);
        chk_loading = 1'b0;
        dly_fixed = -1;
        run_op(1'b0, 1'b1, 2, 2, 15);
        chk_loading = 1'b1;
        cmp_queues("dlsave");
        check_value("dl_latency", 64'((lat >= 0) && (lat <= 3)), 1);
        check_value("dl_dirty", 64'(dirty), 64'(mdirty));

        // Ack timeout
        ena_i = 2'b01; ack_en = 1'b0; exp_load = 1'b1;
        run_op(1'b1, 1'b0, 1, 0, 0);
        check_value("to_rd_cycles", 64'(rd_hi), 64'(c_TO));
        check_value("to_error", 64'(error), 1);
        check_value("to_busy", 64'(busy), 0);
        check_value("to_rd_low", 64'(sd_rd), 0);
        ack_en = 1'b1; hps_st = 0; sd_ack = 1'b0;
        repeat (5) step();
        check_value("error_sticky", 64'(error), 1);

        // Reset taken in WAIT_FALL
        ena_i = 2'b11; dly_fixed = 2;
        strobe(2'b11);
        obs_q.delete();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (hps_st == 2) break;
            step();
        end
        check_value("rst_mid_reach", 64'(hps_st), 2);
        ack_en = 1'b0;
        step();
        check_value("rst_mid_busy_pre", 64'(busy), 1);
        check_value("rst_mid_err_clr", 64'(error), 0);
        reset = 1'b0;
        step();
        check_value("rst_mid_rd", 64'(sd_rd), 0);
        check_value("rst_mid_wr", 64'(sd_wr), 0);
        check_value("rst_mid_busy", 64'(busy), 0);
        check_value("rst_mid_dirty", 64'(dirty), 0);
        check_value("rst_mid_loading", 64'(loading), 0);
        mdirty = '0;
        reset = 1'b1; sd_ack = 1'b0; hps_st = 0; ack_en = 1'b1;
        step();
        exp_q.delete(); model(1'b0, 2'b11);
        run_op(1'b1, 1'b0, 1, 0, 0);
        cmp_queues("rst_reload");

        // Randomized operations
        dly_fixed = -1;
        for (int it = 0; it < 10; it++) begin
            bit op_wr;
            for (int r = 0; r < c_NR; r++) begin
                if ($urandom_range(0, 5) == 0) tb_mask[r] = '0;
                else tb_mask[r] = 24'(($urandom_range(0, 4) << c_SB) | $urandom_range(0, 511));
                tb_base[r] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom());
            end
            ena_i = 2'($urandom_range(0, 3));
            strobe(2'($urandom_range(0, 3)));
            op_wr = 1'($urandom_range(0, 1));
            exp_q.delete(); model(op_wr, ena_i);
            exp_load = ~op_wr;
            run_op(~op_wr, op_wr, 1, 0, 0);
            cmp_queues($sformatf("rnd%0d", it));
            check_value($sformatf("rnd%0d_dirty", it), 64'(dirty), 64'(mdirty));
            check_value($sformatf("rnd%0d_error", it), 64'(error), 0);
            check_value($sformatf("rnd%0d_dclr", it), 64'(dirty_clr_bad), 0);
            check_value($sformatf("rnd%0d_loading", it), 64'(loading_bad), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
